// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: N-channel, W-bit registered multiplexer with valid/ready on
// every channel and on the output. In manual mode sel picks the channel. In
// scan mode an internal pointer visits the channels round-robin, dwelling
// dwell+1 cycles on each one.

// Per-channel handshake slice: raises ready when this lane is the active
// channel and the output slot can take a word, and fires on valid&ready.
module mux_nx1_scan_lane #(
  parameter int IDX   = 0,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0] act_i,
  input  logic             act_ok_i,
  input  logic             free_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             fire_o
);
  // ready never looks at valid, so producers may wait on it safely
  assign ready_o = act_ok_i && free_i && (act_i == SEL_W'(IDX));
  assign fire_o  = ready_o && valid_i;
endmodule

module mux_nx1_scan #(
  parameter int N_CH    = 4,
  parameter int W       = 8,
  parameter int DWELL_W = 4,
  parameter int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                mode_i,
  input  logic [SEL_W-1:0]    sel_i,
  input  logic [DWELL_W-1:0]  dwell_i,
  input  logic [N_CH*W-1:0]   in_data_i,
  input  logic [N_CH-1:0]     in_valid_i,
  output logic [N_CH-1:0]     in_ready_o,
  output logic [W-1:0]        out_data_o,
  output logic [SEL_W-1:0]    out_ch_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                wrap_o,
  output logic                sel_err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_MANUAL, ST_SCAN} state_e;

  // sel is widened by one bit so sel >= N_CH is representable for any N_CH
  localparam logic [SEL_W:0]   NCH_EXT = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]         out_data_q, out_data_d;
  logic [SEL_W-1:0]     out_ch_q, out_ch_d;
  logic                 out_valid_q, out_valid_d;
  logic                 wrap_q, wrap_d;
  logic                 sel_err_q, sel_err_d;

  logic                      sel_ok;
  logic [SEL_W-1:0]          act;
  logic                      act_ok;
  logic                      free;
  logic [N_CH-1:0]           fire;
  logic                      load;
  logic [W-1:0]              ld_data;
  logic [N_CH-1:0][W-1:0]    ch_data;

  assign ch_data = in_data_i;
  assign sel_ok  = ({1'b0, sel_i} < NCH_EXT);
  assign free    = !out_valid_q || out_ready_i;
  assign load    = |fire;

  // Mode/enable decode: en low parks in IDLE, otherwise mode is followed every cycle
  always_comb begin
    state_d = ST_IDLE;
    if (en_i) state_d = mode_i ? ST_SCAN : ST_MANUAL;
  end

  // Active channel comes from the registered state; IDLE and a bad sel have none
  always_comb begin
    act    = ptr_q;
    act_ok = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        act    = sel_i;
        act_ok = sel_ok;
      end
      ST_SCAN: begin
        act    = ptr_q;
        act_ok = 1'b1;
      end
      default: begin
        act    = ptr_q;
        act_ok = 1'b0;
      end
    endcase
  end

  // One handshake slice per channel; at most one can fire since act is a single index
  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    mux_nx1_scan_lane #(.IDX(k), .SEL_W(SEL_W)) u_lane (
      .act_i    (act),
      .act_ok_i (act_ok),
      .free_i   (free),
      .valid_i  (in_valid_i[k]),
      .ready_o  (in_ready_o[k]),
      .fire_o   (fire[k])
    );
  end

  // AND-OR data mux driven by the fire vector, never indexes past N_CH-1
  always_comb begin
    ld_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (fire[k]) ld_data = ld_data | ch_data[k];
    end
  end

  // Pointer, dwell counter, output slot and error flag next-state
  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    wrap_d      = 1'b0;
    sel_err_d   = sel_err_q;
    out_valid_d = load || (out_valid_q && !out_ready_i);
    out_data_d  = load ? ld_data : out_data_q;
    out_ch_d    = load ? act : out_ch_q;
    case (state_q)
      ST_SCAN: begin
        // counts cycles, not transfers; a transfer this cycle already used old ptr
        if (cnt_q == dwell_i) begin
          cnt_d  = '0;
          ptr_d  = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
          wrap_d = (ptr_q == LAST_CH);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_MANUAL: begin
        // track sel so a later switch to scan resumes on this channel
        cnt_d = '0;
        if (sel_ok) ptr_d = sel_i;
        else        sel_err_d = 1'b1;
      end
      default: begin
        // IDLE clears the counter so scan always starts a fresh dwell
        cnt_d = '0;
      end
    endcase
  end

  // State and all registered outputs; reset discards any held word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;
  assign out_valid_o = out_valid_q;
  assign wrap_o      = wrap_q;
  assign sel_err_o   = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan: a 4-channel and a 3-channel instance.
module tb_mux_nx1_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // 4-channel instance
  logic        en4 = 0, mode4 = 0, ordy4 = 0;
  logic [1:0]  sel4 = 0;
  logic [3:0]  dwell4 = 0;
  logic [31:0] data4 = 0;
  logic [3:0]  valid4 = 0;
  logic [3:0]  ready4;
  logic [7:0]  odata4;
  logic [1:0]  och4;
  logic        ovalid4, wrap4, err4;

  // 3-channel instance
  logic        en3 = 0, mode3 = 0, ordy3 = 0;
  logic [1:0]  sel3 = 0;
  logic [3:0]  dwell3 = 0;
  logic [23:0] data3 = 0;
  logic [2:0]  valid3 = 0;
  logic [2:0]  ready3;
  logic [7:0]  odata3;
  logic [1:0]  och3;
  logic        ovalid3, wrap3, err3;

  mux_nx1_scan #(.N_CH(4), .W(8), .DWELL_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en_i(en4), .mode_i(mode4), .sel_i(sel4),
    .dwell_i(dwell4), .in_data_i(data4), .in_valid_i(valid4), .in_ready_o(ready4),
    .out_data_o(odata4), .out_ch_o(och4), .out_valid_o(ovalid4),
    .out_ready_i(ordy4), .wrap_o(wrap4), .sel_err_o(err4)
  );

  mux_nx1_scan #(.N_CH(3), .W(8), .DWELL_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en_i(en3), .mode_i(mode3), .sel_i(sel3),
    .dwell_i(dwell3), .in_data_i(data3), .in_valid_i(valid3), .in_ready_o(ready3),
    .out_data_o(odata3), .out_ch_o(och3), .out_valid_o(ovalid3),
    .out_ready_i(ordy3), .wrap_o(wrap3), .sel_err_o(err3)
  );

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step;
    tests++;
    if ({odata4, och4, ovalid4, wrap4, err4, ready4} !== 17'h0) begin
      fails++;
      $display("FAIL reset4: got data=%h ch=%0d v=%b wrap=%b err=%b rdy=%b want all 0",
               odata4, och4, ovalid4, wrap4, err4, ready4);
    end
    tests++;
    if ({odata3, och3, ovalid3, wrap3, err3, ready3} !== 16'h0) begin
      fails++;
      $display("FAIL reset3: got data=%h ch=%0d v=%b wrap=%b err=%b rdy=%b want all 0",
               odata3, och3, ovalid3, wrap3, err3, ready3);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_manual;
    logic [7:0] exp;
    en4 = 1; mode4 = 0; sel4 = 0; valid4 = 4'hF; data4 = 32'h44332211; ordy4 = 1;
    step; // IDLE -> MANUAL, nothing loaded yet
    tests++;
    if (ovalid4 !== 1'b0) begin
      fails++; $display("FAIL manual_first: out_valid got %b want 0", ovalid4);
    end
    for (int k = 0; k < 4; k++) begin
      sel4 = 2'(k);
      #1;
      tests++;
      if (ready4 !== 4'(1 << k)) begin
        fails++; $display("FAIL manual_ready[%0d]: got %b want %b", k, ready4, 4'(1 << k));
      end
      step;
      exp = 8'(8'h11 * (k + 1));
      tests++;
      if (odata4 !== exp || och4 !== 2'(k) || ovalid4 !== 1'b1) begin
        fails++;
        $display("FAIL manual_out[%0d]: got data=%h ch=%0d v=%b want data=%h ch=%0d v=1",
                 k, odata4, och4, ovalid4, exp, k);
      end
    end
  endtask

  task automatic test_backpressure;
    sel4 = 2;
    step;
    tests++;
    if (odata4 !== 8'h33 || och4 !== 2'd2 || ovalid4 !== 1'b1) begin
      fails++; $display("FAIL bp_load: got data=%h ch=%0d v=%b want 33/2/1", odata4, och4, ovalid4);
    end
    ordy4 = 0;
    data4 = 32'h44A52211;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (ready4 !== 4'b0000) begin
        fails++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, ready4);
      end
      step;
      tests++;
      if (odata4 !== 8'h33 || ovalid4 !== 1'b1) begin
        fails++; $display("FAIL bp_hold[%0d]: got data=%h v=%b want 33/1", i, odata4, ovalid4);
      end
    end
    ordy4 = 1;
    #1;
    tests++;
    if (ready4 !== 4'b0100) begin
      fails++; $display("FAIL bp_release_ready: got %b want 0100", ready4);
    end
    step;
    tests++;
    if (odata4 !== 8'hA5 || och4 !== 2'd2 || ovalid4 !== 1'b1) begin
      fails++; $display("FAIL bp_popload: got data=%h ch=%0d v=%b want a5/2/1", odata4, och4, ovalid4);
    end
  endtask

  task automatic test_scan;
    logic [1:0] exp_ch;
    logic       exp_wrap;
    data4 = 32'h44332211;
    sel4 = 0;
    step;          // manual load of ch0, pointer parked on 0
    mode4 = 1; dwell4 = 1;
    step;          // MANUAL -> SCAN
    for (int i = 0; i < 16; i++) begin
      step;
      exp_ch   = 2'((i / 2) % 4);
      exp_wrap = (i == 7) || (i == 15);
      tests++;
      if (och4 !== exp_ch || odata4 !== 8'(8'h11 * (exp_ch + 1)) || ovalid4 !== 1'b1
          || wrap4 !== exp_wrap) begin
        fails++;
        $display("FAIL scan[%0d]: got ch=%0d data=%h v=%b wrap=%b want ch=%0d wrap=%b",
                 i, och4, odata4, ovalid4, wrap4, exp_ch, exp_wrap);
      end
    end
  endtask

  task automatic test_nonpow2;
    logic [2:0] exp_rdy [6] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    logic       exp_v   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] exp_ch  [6] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2};
    logic       exp_w   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] exp_d;
    en3 = 1; mode3 = 1; dwell3 = 0; valid3 = 3'b101; data3 = 24'hCCBBAA; ordy3 = 1;
    step; // IDLE -> SCAN
    tests++;
    if (ready3 !== 3'b001) begin
      fails++; $display("FAIL np2_start: ready got %b want 001", ready3);
    end
    for (int i = 0; i < 6; i++) begin
      step;
      exp_d = (exp_ch[i] == 2'd0) ? 8'hAA : 8'hCC;
      tests++;
      if (ready3 !== exp_rdy[i] || ovalid3 !== exp_v[i] || wrap3 !== exp_w[i]
          || och3 !== exp_ch[i] || odata3 !== exp_d) begin
        fails++;
        $display("FAIL np2[%0d]: got rdy=%b v=%b wrap=%b ch=%0d data=%h want rdy=%b v=%b wrap=%b ch=%0d data=%h",
                 i, ready3, ovalid3, wrap3, och3, odata3,
                 exp_rdy[i], exp_v[i], exp_w[i], exp_ch[i], exp_d);
      end
    end
    mode3 = 0; sel3 = 2'd3;
    step; // SCAN -> MANUAL with an out-of-range select
    tests++;
    if (ready3 !== 3'b000 || err3 !== 1'b0) begin
      fails++; $display("FAIL np2_badsel_enter: got rdy=%b err=%b want 000/0", ready3, err3);
    end
    step;
    tests++;
    if (ready3 !== 3'b000 || err3 !== 1'b1) begin
      fails++; $display("FAIL np2_selerr: got rdy=%b err=%b want 000/1", ready3, err3);
    end
    sel3 = 2'd1;
    step;
    tests++;
    if (ready3 !== 3'b010 || err3 !== 1'b1) begin
      fails++; $display("FAIL np2_sticky: got rdy=%b err=%b want 010/1", ready3, err3);
    end
  endtask

  task automatic test_async_reset;
    // dut4 is still scanning and loading every cycle
    tests++;
    if (ovalid4 !== 1'b1) begin
      fails++; $display("FAIL areset_pre: out_valid got %b want 1", ovalid4);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({odata4, och4, ovalid4, wrap4, err4, ready4} !== 17'h0) begin
      fails++;
      $display("FAIL areset_now: got data=%h ch=%0d v=%b wrap=%b err=%b rdy=%b want all 0",
               odata4, och4, ovalid4, wrap4, err4, ready4);
    end
    step;
    rst_n = 1'b1;
    step; // IDLE -> SCAN, pointer must be back at 0
    tests++;
    if (ready4 !== 4'b0001 || ovalid4 !== 1'b0) begin
      fails++; $display("FAIL areset_restart: got rdy=%b v=%b want 0001/0", ready4, ovalid4);
    end
    step;
    tests++;
    if (och4 !== 2'd0 || odata4 !== 8'h11 || ovalid4 !== 1'b1) begin
      fails++; $display("FAIL areset_first: got ch=%0d data=%h v=%b want 0/11/1", och4, odata4, ovalid4);
    end
  endtask

  task automatic test_idle;
    ordy4 = 0; en4 = 0;
    for (int i = 0; i < 2; i++) begin
      step;
      tests++;
      if (ovalid4 !== 1'b1 || odata4 !== 8'h11 || och4 !== 2'd0 || ready4 !== 4'b0000) begin
        fails++;
        $display("FAIL idle_hold[%0d]: got v=%b data=%h ch=%0d rdy=%b want 1/11/0/0000",
                 i, ovalid4, odata4, och4, ready4);
      end
    end
    ordy4 = 1;
    for (int i = 0; i < 2; i++) begin
      step;
      tests++;
      if (ovalid4 !== 1'b0 || odata4 !== 8'h11 || ready4 !== 4'b0000) begin
        fails++;
        $display("FAIL idle_drain[%0d]: got v=%b data=%h rdy=%b want 0/11/0000",
                 i, ovalid4, odata4, ready4);
      end
    end
  endtask

  initial begin
    test_reset;
    test_manual;
    test_backpressure;
    test_scan;
    test_nonpow2;
    test_async_reset;
    test_idle;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
